// File: rtl/sync_fifo_vr_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_vr_if
// Valid/ready handshake bundle for sync_fifo_vr (producer side and consumer
// side in one interface).
//   s_vld / s_dat / s_rdy : producer -> FIFO write handshake
//   m_vld / m_dat / m_rdy : FIFO -> consumer read handshake
// Modports:
//   slave  : FIFO view (accepts s_*, presents m_*)
//   master : environment view (drives s_* and m_rdy)
// -----------------------------------------------------------------------------
interface sync_fifo_vr_if #(
  parameter int FIFO_W = 32
);
  logic              s_vld;
  logic [FIFO_W-1:0] s_dat;
  logic              s_rdy;
  logic              m_vld;
  logic [FIFO_W-1:0] m_dat;
  logic              m_rdy;

  modport slave (
    input  s_vld, s_dat, m_rdy,
    output s_rdy, m_vld, m_dat
  );

  modport master (
    output s_vld, s_dat, m_rdy,
    input  s_rdy, m_vld, m_dat
  );
endinterface

// File: rtl/sync_fifo_vr.sv
// -----------------------------------------------------------------------------
// sync_fifo_vr
// Single-clock FIFO with valid/ready handshakes on both sides, first-word-
// fall-through head, live almost-full/almost-empty thresholds and flush.
// Depth need not be a power of two; pointers wrap explicitly at FIFO_D-1.
//
// Ports:
//   clk, rstn   : rising-edge clock, asynchronous active-low reset
//   bus         : sync_fifo_vr_if.slave (s_vld/s_dat/s_rdy, m_vld/m_dat/m_rdy)
//   fifo_fsh    : synchronous flush, wins over push/pop in the same cycle
//   afull_th    : almost-full threshold  (fifo_afull = level >= afull_th)
//   aempt_th    : almost-empty threshold (fifo_aempt = level <= aempt_th)
//   fifo_len    : current occupancy
//   clr_stat    : clears the statistics counters
//   peak_len    : maximum occupancy since reset/clear
//   stall_cnt   : saturating count of cycles with s_vld=1 and s_rdy=0
//
// Build option: define SYNC_FIFO_VR_STAT_EN to build the statistics counters;
// otherwise peak_len/stall_cnt read 0 and clr_stat is ignored.
// -----------------------------------------------------------------------------
module sync_fifo_vr #(
  parameter int FIFO_D   = 12,
  parameter int FIFO_W   = 32,
  parameter int FIFO_ADR = $clog2(FIFO_D)
) (
  input  logic                clk,
  input  logic                rstn,
  sync_fifo_vr_if.slave       bus,
  input  logic                fifo_fsh,
  input  logic [FIFO_ADR:0]   afull_th,
  input  logic [FIFO_ADR:0]   aempt_th,
  output logic                fifo_afull,
  output logic                fifo_aempt,
  output logic [FIFO_ADR:0]   fifo_len,
  input  logic                clr_stat,
  output logic [FIFO_ADR:0]   peak_len,
  output logic [15:0]         stall_cnt
);

  localparam logic [FIFO_ADR:0]   LVL_FULL = (FIFO_ADR+1)'(FIFO_D);
  localparam logic [FIFO_ADR:0]   LVL_ONE  = (FIFO_ADR+1)'(1);
  localparam logic [FIFO_ADR-1:0] PTR_LAST = FIFO_ADR'(FIFO_D-1);
  localparam logic [FIFO_ADR-1:0] PTR_ONE  = FIFO_ADR'(1);

  logic [FIFO_W-1:0]   mem_r [FIFO_D];
  logic [FIFO_ADR-1:0] wptr_r;
  logic [FIFO_ADR-1:0] rptr_r;
  logic [FIFO_ADR:0]   lvl_r;
  logic [FIFO_ADR:0]   lvl_nxt_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [FIFO_ADR-1:0] ptr_inc(input logic [FIFO_ADR-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end else begin
      return ptr + PTR_ONE;
    end
  endfunction

  // Status is derived from the level register only, never from s_vld/m_rdy,
  // so push-on-full and pop-on-empty cannot happen.
  assign full_s  = (lvl_r == LVL_FULL);
  assign empty_s = (lvl_r == '0);
  assign push_s  = bus.s_vld & ~full_s;
  assign pop_s   = bus.m_rdy & ~empty_s;

  assign bus.s_rdy  = ~full_s;
  assign bus.m_vld  = ~empty_s;
  assign bus.m_dat  = mem_r[rptr_r];
  assign fifo_len   = lvl_r;
  assign fifo_afull = (lvl_r >= afull_th);
  assign fifo_aempt = (lvl_r <= aempt_th);

  // Next occupancy: flush first, then the net effect of push/pop.
  always_comb begin
    lvl_nxt_s = lvl_r;
    if (fifo_fsh) begin
      lvl_nxt_s = '0;
    end else if (push_s && !pop_s) begin
      lvl_nxt_s = lvl_r + LVL_ONE;
    end else if (pop_s && !push_s) begin
      lvl_nxt_s = lvl_r - LVL_ONE;
    end else begin
      lvl_nxt_s = lvl_r;
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_r <= '0;
      rptr_r <= '0;
      lvl_r  <= '0;
    end else if (fifo_fsh) begin
      wptr_r <= '0;
      rptr_r <= '0;
      lvl_r  <= '0;
    end else begin
      if (push_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      lvl_r <= lvl_nxt_s;
    end
  end

  // Storage array; cleared by reset only, flush leaves contents in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_D; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s && !fifo_fsh) begin
      mem_r[wptr_r] <= bus.s_dat;
    end
  end

`ifdef SYNC_FIFO_VR_STAT_EN
  logic [FIFO_ADR:0] peak_r;
  logic [15:0]       stall_r;

  // Occupancy high-water mark and saturating producer-stall counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_r  <= '0;
      stall_r <= 16'h0000;
    end else if (clr_stat) begin
      peak_r  <= '0;
      stall_r <= 16'h0000;
    end else begin
      if (lvl_nxt_s > peak_r) begin
        peak_r <= lvl_nxt_s;
      end
      if (bus.s_vld && full_s && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'h0001;
      end
    end
  end

  assign peak_len  = peak_r;
  assign stall_cnt = stall_r;
`else
  logic unused_clr_s;
  assign unused_clr_s = clr_stat;
  assign peak_len     = '0;
  assign stall_cnt    = 16'h0000;
`endif

endmodule

// File: doc/sync_fifo_vr.md
# sync_fifo_vr

Synchronous single-clock FIFO with valid/ready handshakes on both sides, first-word-fall-through output, runtime-programmable almost-full/almost-empty thresholds, flush, and optional occupancy statistics. It supersedes the plain we/re FIFO wherever a producer or consumer needs backpressure rather than overflow/underflow error strobes. It sits between pipeline stages and bus adapters.

## Interface
- FIFO_D, 12, entry count; any value ≥ 2, power of two not required
- FIFO_W, 32, data width in bits
- FIFO_ADR, $clog2(FIFO_D), derived pointer width; not overridden
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- s_vld  in  1  producer has data
- s_dat  in  FIFO_W  producer data
- s_rdy  out  1  FIFO can accept; equals ~full
- m_vld  out  1  head entry valid; equals ~empty
- m_dat  out  FIFO_W  head entry, FWFT
- m_rdy  in  1  consumer takes head
- fifo_fsh  in  1  synchronous flush
- afull_th  in  FIFO_ADR+1  almost-full threshold
- aempt_th  in  FIFO_ADR+1  almost-empty threshold
- fifo_afull  out  1  level ≥ afull_th
- fifo_aempt  out  1  level ≤ aempt_th
- fifo_len  out  FIFO_ADR+1  current occupancy
- clr_stat  in  1  clear statistics
- peak_len  out  FIFO_ADR+1  maximum occupancy since reset/clear
- stall_cnt  out  16  cycles with s_vld=1 and s_rdy=0, saturating

## Operation
- Push = s_vld & s_rdy; pop = m_vld & m_rdy. Both are evaluated in the same cycle and are independent.
- Write pointer and read pointer run 0..FIFO_D-1 and wrap to 0 after FIFO_D-1, for both power-of-two and non-power-of-two depths.
- Level register: +1 on push only, −1 on pop only, unchanged on both or neither. Range is 0..FIFO_D.
- Full is level==FIFO_D; empty is level==0. Push when full and pop when empty are impossible by construction. No error flags are produced.
- Push and pop together when full is impossible, because s_rdy=0. When empty, only the push occurs, and the entry appears at the head the next cycle; there is no bypass.
- m_dat = mem[rptr], combinational from registers. It is meaningful only while m_vld=1.
- Flush has priority over push/pop in the same cycle. It zeroes the pointers and level; memory contents are kept. An s_vld coinciding with flush is not stored.
- Thresholds are sampled live. afull_th=0 makes fifo_afull constantly 1. aempt_th ≥ FIFO_D makes fifo_aempt constantly 1.
- Memory is reset to 0 by rstn only.

## Timing
- Reset values: s_rdy=1, m_vld=0, m_dat=0, fifo_len=0, fifo_aempt=1, fifo_afull=(afull_th==0), peak_len=0, stall_cnt=0.
- Write-to-read latency is 1 cycle: a push at edge N gives m_vld=1 with that data after edge N.
- s_rdy, m_vld, fifo_len, fifo_afull and fifo_aempt all update after the edge that changes the level. None depends combinationally on s_vld or m_rdy.
- Flush at edge N gives level 0, s_rdy=1 and m_vld=0 after edge N.
- rstn assertion mid-transfer clears all state immediately, with no clock required. Transfers resume on the first edge after deassertion.

## Configuration
- SYNC_FIFO_VR_STAT_EN defined:
  - peak_len is updated to max(peak_len, next level) every cycle.
  - stall_cnt increments per cycle with s_vld & ~s_rdy and saturates at 16'hFFFF.
  - clr_stat zeroes both counters and has priority over updates. Flush does not clear them.
- Macro undefined: peak_len and stall_cnt are tied to 0, clr_stat is ignored, and no statistics flops are built. Ports remain present.

## Test plan
- FIFO_D=12, fill with 0..11 while m_rdy=0 → s_rdy=0 after 12th push; fifo_len=12; peak_len=12. Drain → 0..11 in order, m_vld=0 after the last.
- FIFO_D=12, continuous push+pop for 40 cycles with level held at 5 → fifo_len stays 5; pointers wrap 11→0 with no data loss or reorder.
- afull_th=10, aempt_th=2 → fifo_aempt=1 at levels 0..2; fifo_afull=1 at levels 10..12; both 0 at level 5.
- Level 7, then fifo_fsh together with s_vld=1 and m_rdy=1 → next cycle fifo_len=0, m_vld=0, s_rdy=1; the coinciding data is not stored.
- STAT_EN, full FIFO, s_vld held 70000 cycles → stall_cnt=16'hFFFF. Then clr_stat → stall_cnt=0, peak_len=0.
- Assert rstn low at level 6 mid-burst → outputs take reset values without a clock edge; the first push after release appears at m_dat one cycle later.
